ram_arbiter: RTL

//   Shares the single SDRAM controller port (rd/we/ready) among four requesters: ioctl DMA

---
 rtl/ram_arbiter.sv | 166 ++++++++++++++++
 1 files changed

// File: rtl/ram_arbiter.sv
// Four-way SDRAM port arbiter: fixed priority dma > tape > fdd > cpu with a CPU
// anti-starvation override, ISSUE/WAIT/DONE sequencing, timeout and one-cycle ack.
module ram_arbiter #(
    parameter int AW           = 25,
    parameter int STARVE_LIMIT = 4,
    parameter int TIMEOUT      = 255
) (
    input  logic          clk_sys,
    input  logic          reset,

    input  logic          dma_req,
    input  logic [AW-1:0] dma_addr,
    input  logic [7:0]    dma_din,

    input  logic          tape_req,
    input  logic [AW-1:0] tape_addr,

    input  logic          fdd_req,
    input  logic [AW-1:0] fdd_addr,

    input  logic          cpu_req,
    input  logic          cpu_we,
    input  logic [AW-1:0] cpu_addr,
    input  logic [7:0]    cpu_din,

    output logic [3:0]    ack,
    output logic [7:0]    rd_data,
    output logic          err,
    output logic          cpu_wait,

    output logic [AW-1:0] mem_addr,
    output logic [7:0]    mem_din,
    output logic          mem_rd,
    output logic          mem_we,
    input  logic [7:0]    mem_dout,
    input  logic          mem_ready
);

    localparam int         SW    = $clog2(STARVE_LIMIT + 1);
    localparam logic [SW-1:0] SLIM  = SW'(STARVE_LIMIT);
    localparam logic [7:0]    TLAST = 8'(TIMEOUT - 1);

    localparam logic [1:0] ID_DMA  = 2'd0;
    localparam logic [1:0] ID_TAPE = 2'd1;
    localparam logic [1:0] ID_FDD  = 2'd2;
    localparam logic [1:0] ID_CPU  = 2'd3;

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        WAIT,
        DONE
    } state_t;

    state_t        state;
    logic [1:0]    grant;
    logic          grant_we;
    logic [7:0]    tcnt;
    logic [SW-1:0] starve_cnt;

    logic          win_valid;
    logic [1:0]    win_id;
    logic [AW-1:0] win_addr;
    logic [7:0]    win_din;
    logic          win_we;

    always_comb begin
        win_valid = dma_req | tape_req | fdd_req | cpu_req;
        win_id    = ID_CPU;
        win_addr  = cpu_addr;
        win_din   = cpu_din;
        win_we    = cpu_we;
        if (cpu_req && starve_cnt == SLIM) begin
            win_id = ID_CPU;
        end else if (dma_req) begin
            win_id   = ID_DMA;
            win_addr = dma_addr;
            win_din  = dma_din;
            win_we   = 1'b1;
        end else if (tape_req) begin
            win_id   = ID_TAPE;
            win_addr = tape_addr;
            win_din  = '0;
            win_we   = 1'b0;
        end else if (fdd_req) begin
            win_id   = ID_FDD;
            win_addr = fdd_addr;
            win_din  = '0;
            win_we   = 1'b0;
        end
    end

    assign cpu_wait = cpu_req & ~ack[3];

    // Strobes and ack are registered, so each is loaded on the transition into
    // the state where it must be visible (ISSUE for strobes, DONE for ack).
    always_ff @(posedge clk_sys) begin
        if (reset) begin
            state      <= IDLE;
            grant      <= '0;
            grant_we   <= 1'b0;
            tcnt       <= '0;
            starve_cnt <= '0;
            ack        <= '0;
            rd_data    <= '0;
            err        <= 1'b0;
            mem_addr   <= '0;
            mem_din    <= '0;
            mem_rd     <= 1'b0;
            mem_we     <= 1'b0;
        end else begin
            ack    <= '0;
            err    <= 1'b0;
            mem_rd <= 1'b0;
            mem_we <= 1'b0;
            if (!cpu_req)
                starve_cnt <= '0;

            case (state)
                IDLE: begin
                    if (win_valid && mem_ready) begin
                        grant    <= win_id;
                        grant_we <= win_we;
                        mem_addr <= win_addr;
                        mem_din  <= win_din;
                        mem_we   <= win_we;
                        mem_rd   <= ~win_we;
                        state    <= ISSUE;
                        if (win_id == ID_CPU)
                            starve_cnt <= '0;
                        else if (cpu_req && starve_cnt != SLIM)
                            starve_cnt <= starve_cnt + 1'b1;
                    end
                end

                ISSUE: begin
                    tcnt  <= '0;
                    state <= WAIT;
                end

                WAIT: begin
                    // tcnt==0 marks the first WAIT cycle, where mem_ready is stale
                    if (tcnt != 8'd0 && mem_ready) begin
                        ack[grant] <= 1'b1;
                        rd_data    <= grant_we ? 8'hFF : mem_dout;
                        state      <= DONE;
                    end else if (tcnt == TLAST) begin
                        ack[grant] <= 1'b1;
                        rd_data    <= 8'hFF;
                        err        <= 1'b1;
                        state      <= DONE;
                    end else begin
                        tcnt <= tcnt + 8'd1;
                    end
                end

                DONE: begin
                    state <= IDLE;
                end

                default: state <= IDLE;
            endcase
        end
    end

endmodule
